clk_div_prog: RTL and testbench

CLK_DIV_PROG -- requirements
Module: clk_div_prog

---
 rtl/clk_div_pkg.sv | 13 +
 rtl/clk_div_core.sv | 55 +++++
 rtl/clk_div_prog.sv | 62 ++++++
 tb/tb_clk_div_prog.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants and divisor clamp helper
// for the programmable clock divider.
package clk_div_pkg;
  localparam int DIV_W_DEF = 8;
  localparam int DEFAULT_DIV_DEF = 4;
  localparam int unsigned MIN_DIV = 2;

  function automatic int unsigned clamp_div(
    input int unsigned v
  );
    return (v < MIN_DIV) ? MIN_DIV : v;
  endfunction
endpackage

// File: rtl/clk_div_core.sv
// Divider core: period counter, phase flops
// and 50% duty clock generation.
module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] i_div,
  input  logic             i_start,
  output logic             o_bound,
  output logic             o_clk
);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] w_inc;
  logic [DIV_W:0]   w_half;
  logic             w_p_nxt;
  logic             r_p;
  logic             r_q;

  assign w_inc   = r_cnt + DIV_W'(1);
  assign w_half  = ({1'b0, i_div}
                 + {{DIV_W{1'b0}}, 1'b1}) >> 1;
  assign o_bound = (r_cnt == i_div - DIV_W'(1));
  assign w_p_nxt = ({1'b0, w_inc} < w_half);

  // Stopped state parks cnt at N-1 so the
  // boundary stays visible for a restart.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= DIV_W'(DEFAULT_DIV - 1);
      r_p   <= 1'b0;
    end else if (i_start) begin
      r_cnt <= '0;
      r_p   <= 1'b1;
    end else if (o_bound) begin
      r_p   <= 1'b0;
    end else begin
      r_cnt <= w_inc;
      r_p   <= w_p_nxt;
    end
  end

  always_ff @(negedge clk_in or negedge rst_n) begin
    if (!rst_n) r_q <= 1'b0;
    else        r_q <= r_p;
  end

  // Odd N trims half a cycle off the rise.
  assign o_clk = i_div[0] ? (r_p & r_q) : r_p;

endmodule

// File: rtl/clk_div_prog.sv
// Programmable clock divider: divisor staging,
// run control and rising-edge strobe.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] div_val,
  input  logic             div_load,
  output logic             clk_out,
  output logic             clk_pulse,
  output logic [DIV_W-1:0] cur_div
);

  localparam logic [DIV_W-1:0] RST_DIV =
    DIV_W'(DEFAULT_DIV);

  logic [DIV_W-1:0] r_pend;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] w_clamp;
  logic [DIV_W-1:0] w_next;
  logic             w_bound;
  logic             w_start;
  logic             r_pulse;

  assign w_clamp = DIV_W'(clamp_div(32'(div_val)));
  // A strobe on the boundary edge itself wins.
  assign w_next  = div_load ? w_clamp : r_pend;
  assign w_start = w_bound & en;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_pend  <= RST_DIV;
      r_div   <= RST_DIV;
      r_pulse <= 1'b0;
    end else begin
      if (div_load) r_pend <= w_clamp;
      if (w_start)  r_div  <= w_next;
      r_pulse <= w_start;
    end
  end

  assign cur_div   = r_div;
  assign clk_pulse = r_pulse;

  clk_div_core #(
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_core (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .i_div   (r_div),
    .i_start (w_start),
    .o_bound (w_bound),
    .o_clk   (clk_out)
  );

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed table-driven bench for clk_div_prog
// with hand sequences for odd N and async reset.
module tb_clk_div_prog;

  logic       clk_in;
  logic       rst_n;
  logic       en;
  logic [7:0] div_val;
  logic       div_load;
  logic       clk_out;
  logic       clk_pulse;
  logic [7:0] cur_div;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       en;
    logic       ld;
    logic [7:0] val;
    logic       out;
    logic       pulse;
    logic [7:0] div;
  } vec_t;

  vec_t tv[32];

  clk_div_prog #(
    .DIV_W       (8),
    .DEFAULT_DIV (4)
  ) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .en        (en),
    .div_val   (div_val),
    .div_load  (div_load),
    .clk_out   (clk_out),
    .clk_pulse (clk_pulse),
    .cur_div   (cur_div)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  function automatic vec_t mk(
    input logic e, input logic l, input int v,
    input logic o, input logic p, input int d
  );
    vec_t t;
    t.en = e; t.ld = l; t.val = 8'(v);
    t.out = o; t.pulse = p; t.div = 8'(d);
    return t;
  endfunction

  task automatic chk(input string nm,
                     input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    bit got;
    int exp_pos[3];
    int exp_neg[3];
    int exp_pul[3];

    // N=4 run, load 6 mid-period, stop/restart
    // with clamped 0, then load on a boundary.
    tv[0]  = mk(1, 0, 0, 1, 1, 4);
    tv[1]  = mk(1, 0, 0, 1, 0, 4);
    tv[2]  = mk(1, 0, 0, 0, 0, 4);
    tv[3]  = mk(1, 0, 0, 0, 0, 4);
    tv[4]  = mk(1, 0, 0, 1, 1, 4);
    tv[5]  = mk(1, 0, 0, 1, 0, 4);
    tv[6]  = mk(1, 1, 6, 0, 0, 4);
    tv[7]  = mk(1, 0, 0, 0, 0, 4);
    tv[8]  = mk(1, 0, 0, 1, 1, 6);
    tv[9]  = mk(1, 0, 0, 1, 0, 6);
    tv[10] = mk(1, 0, 0, 1, 0, 6);
    tv[11] = mk(1, 0, 0, 0, 0, 6);
    tv[12] = mk(1, 0, 0, 0, 0, 6);
    tv[13] = mk(1, 0, 0, 0, 0, 6);
    tv[14] = mk(1, 0, 0, 1, 1, 6);
    tv[15] = mk(0, 0, 0, 1, 0, 6);
    tv[16] = mk(0, 0, 0, 1, 0, 6);
    tv[17] = mk(0, 0, 0, 0, 0, 6);
    tv[18] = mk(0, 0, 0, 0, 0, 6);
    tv[19] = mk(0, 0, 0, 0, 0, 6);
    tv[20] = mk(0, 0, 0, 0, 0, 6);
    tv[21] = mk(0, 1, 0, 0, 0, 6);
    tv[22] = mk(0, 0, 0, 0, 0, 6);
    tv[23] = mk(1, 0, 0, 1, 1, 2);
    tv[24] = mk(1, 0, 0, 0, 0, 2);
    tv[25] = mk(1, 0, 0, 1, 1, 2);
    tv[26] = mk(1, 0, 0, 0, 0, 2);
    tv[27] = mk(1, 1, 4, 1, 1, 4);
    tv[28] = mk(1, 0, 0, 1, 0, 4);
    tv[29] = mk(1, 0, 0, 0, 0, 4);
    tv[30] = mk(1, 0, 0, 0, 0, 4);
    tv[31] = mk(1, 0, 0, 1, 1, 4);

    rst_n = 1'b0; en = 1'b0;
    div_val = '0; div_load = 1'b0;
    #12;
    chk("rst_out",   int'(clk_out),   0);
    chk("rst_pulse", int'(clk_pulse), 0);
    chk("rst_div",   int'(cur_div),   4);
    step();
    rst_n = 1'b1;

    for (int i = 0; i < 32; i++) begin
      en = tv[i].en;
      div_load = tv[i].ld;
      div_val = tv[i].val;
      step();
      chk($sformatf("v%0d_out", i),
          int'(clk_out), int'(tv[i].out));
      chk($sformatf("v%0d_pulse", i),
          int'(clk_pulse), int'(tv[i].pulse));
      chk($sformatf("v%0d_div", i),
          int'(cur_div), int'(tv[i].div));
    end

    // Odd N=3 at half-cycle resolution.
    div_load = 1'b1; div_val = 8'd3;
    step();
    div_load = 1'b0; div_val = '0;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      step();
      if (cur_div == 8'd3) got = 1'b1;
    end
    chk("odd_wait", int'(got), 1);
    exp_pos = '{0, 1, 0};
    exp_neg = '{1, 1, 0};
    exp_pul = '{1, 0, 0};
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("odd%0d_pos", k),
          int'(clk_out), exp_pos[k % 3]);
      chk($sformatf("odd%0d_pulse", k),
          int'(clk_pulse), exp_pul[k % 3]);
      @(negedge clk_in);
      #1;
      chk($sformatf("odd%0d_neg", k),
          int'(clk_out), exp_neg[k % 3]);
      step();
    end
    chk("odd_div", int'(cur_div), 3);

    // Reset mid-period with a pending 7.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
    chk("rst2_out", int'(clk_out), 1);
    chk("rst2_div", int'(cur_div), 4);
    div_load = 1'b1; div_val = 8'd7;
    step();
    div_load = 1'b0; div_val = '0;
    chk("pre_rst_out", int'(clk_out), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_out",   int'(clk_out),   0);
    chk("async_pulse", int'(clk_pulse), 0);
    chk("async_div",   int'(cur_div),   4);
    step();
    rst_n = 1'b1;
    exp_pos = '{1, 1, 0};
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("post%0d_out", k), int'(clk_out),
          (k % 4 < 2) ? 1 : 0);
      chk($sformatf("post%0d_pulse", k),
          int'(clk_pulse), (k % 4 == 0) ? 1 : 0);
      chk($sformatf("post%0d_div", k),
          int'(cur_div), 4);
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
